// File: rtl/trace_buf_ctrl.sv
// trace_buf_ctrl
//   Write-side controller for the per-cluster instruction trace buffer.
//   Accepts packed trace records, drives BRAM port A (write strobe, ring
//   address, data) with one cycle of latency, tracks the unflushed fill
//   level, stalls the cores at a threshold and reopens on host flush.
//
// Ports
//   ref_clk_i, rst_i      clock, asynchronous active-high reset
//   fetch_en_i            cluster fetch enable (0 forces IDLE)
//   cg_clken_i            cluster clock-gate enable (records accepted only when 1)
//   rec_valid_i           record valid from capture stage
//   rec_core_mask_i       contributing cores (all-zero = not valid)
//   rec_data_i            record payload
//   rec_ready_o           record accepted this cycle if rec_valid_i is also 1
//   mem_we_o/addr_o/din_o BRAM port-A write interface
//   trace_wait_o          stall request to the cores
//   trace_flushed_i       host pulse: pending lines have been read
//   base_addr_o           line address of the oldest unflushed record
//   fill_level_o          number of unflushed lines
//   overflow_o            sticky: a record was dropped while full
//   state_o               FSM state (0 IDLE, 1 RUN, 2 HOLD)
module trace_buf_ctrl #(
    parameter int unsigned NB_CORES         = 4,
    parameter int unsigned TRACE_BUFFER_DIM = 1024,
    parameter int unsigned REC_WIDTH        = 512,
    parameter int unsigned TRACE_THRESHOLD  = 1000,
    localparam int unsigned AW = (TRACE_BUFFER_DIM > 1) ? $clog2(TRACE_BUFFER_DIM) : 1,
    localparam int unsigned FW = AW + 1
) (
    input  logic                 ref_clk_i,
    input  logic                 rst_i,
    input  logic                 fetch_en_i,
    input  logic                 cg_clken_i,
    input  logic                 rec_valid_i,
    input  logic [NB_CORES-1:0]  rec_core_mask_i,
    input  logic [REC_WIDTH-1:0] rec_data_i,
    output logic                 rec_ready_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [REC_WIDTH-1:0] mem_din_o,
    output logic                 trace_wait_o,
    input  logic                 trace_flushed_i,
    output logic [AW-1:0]        base_addr_o,
    output logic [FW-1:0]        fill_level_o,
    output logic                 overflow_o,
    output logic [1:0]           state_o
);

    if (TRACE_THRESHOLD < 1 || TRACE_THRESHOLD > TRACE_BUFFER_DIM) begin : g_bad_threshold
        $error("trace_buf_ctrl: TRACE_THRESHOLD must be in 1..TRACE_BUFFER_DIM");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   wr_ptr, wr_ptr_n;
    logic [AW-1:0]   base, base_n;
    logic [FW-1:0]   fill, fill_n;
    logic            overflow, overflow_n;
    logic            active;
    logic            not_full;
    logic            rec_present;
    logic            accept;
    logic            drop;

    // fetch_en_i gates ready so a record is never acknowledged in the
    // cycle the controller is being taken back to IDLE.
    assign active      = fetch_en_i && (state != IDLE);
    assign not_full    = (fill < FW'(TRACE_BUFFER_DIM));
    assign rec_present = rec_valid_i && (|rec_core_mask_i);
    assign rec_ready_o = active && cg_clken_i && not_full;
    assign accept      = rec_present && rec_ready_o;
    assign drop        = rec_present && active && cg_clken_i && !not_full;

    always_comb begin
        state_n    = state;
        wr_ptr_n   = wr_ptr;
        base_n     = base;
        fill_n     = fill;
        overflow_n = overflow;
        if (state == IDLE) begin
            if (fetch_en_i) begin
                state_n    = RUN;
                wr_ptr_n   = '0;
                base_n     = '0;
                fill_n     = '0;
                overflow_n = 1'b0;
            end
        end else if (!fetch_en_i) begin
            state_n = IDLE;
        end else begin
            if (accept) begin
                wr_ptr_n = (wr_ptr == AW'(TRACE_BUFFER_DIM - 1)) ? '0 : wr_ptr + AW'(1);
            end
            // A flush retires every old line; a record accepted alongside it
            // lands at the current pointer and becomes the new oldest line.
            if (trace_flushed_i) begin
                base_n = wr_ptr;
                fill_n = accept ? FW'(1) : '0;
            end else if (accept) begin
                fill_n = fill + FW'(1);
            end
            if (drop) begin
                overflow_n = 1'b1;
            end
            if (state == HOLD) begin
                if (trace_flushed_i) begin
                    state_n = RUN;
                end
            end else if (accept && (fill_n >= FW'(TRACE_THRESHOLD))) begin
                state_n = HOLD;
            end
        end
    end

    always_ff @(posedge ref_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            base     <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            wr_ptr   <= wr_ptr_n;
            base     <= base_n;
            fill     <= fill_n;
            overflow <= overflow_n;
        end
    end

    always_ff @(posedge ref_clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_din_o  <= '0;
        end else begin
            mem_we_o <= accept;
            if (accept) begin
                mem_addr_o <= wr_ptr;
                mem_din_o  <= rec_data_i;
            end
        end
    end

    assign trace_wait_o = (state == HOLD);
    assign base_addr_o  = base;
    assign fill_level_o = fill;
    assign overflow_o   = overflow;
    assign state_o      = state;

endmodule
